rr_arbiter_8: RTL and testbench
===============================

Name: rr_arbiter_8

Overview:
Round-robin arbiter that shares one downstream resource among 8 requesters. It is built around a masked priority encoder. Grants are registered, and a grant is held while its requester keeps its request asserted. A configurable hold limit forces rotation so one requester cannot starve the others. It sits in front of any shared datapath that previously took a raw, combinational 8:3 priority-encoded selection.

Parameters:
N_REQ, 8, number of requesters; fixed at 8 for this revision.
IDX_W, 3, width of the grant index; equals clog2(N_REQ).
MAX_HOLD, 16, maximum consecutive grant cycles while others wait; 0 disables the limit; legal range 0..255.

Ports:
clk  in  1  single clock, rising-edge.
rst_n  in  1  asynchronous, active-low reset.
req  in  N_REQ  request vector; bit i is requester i, level-sensitive.
gnt  out  N_REQ  one-hot grant, registered; all zeros when no grant.
gnt_idx  out  IDX_W  binary index of the granted requester; 0 when gnt_valid=0.
gnt_valid  out  1  high while any grant is active.
preempt  out  1  one-cycle pulse in the cycle a grant is revoked by the hold limit.
idle  out  1  high in the IDLE state.

Behaviour:
- Reset (async assert, sync release):
  - Outputs: gnt=0, gnt_idx=0, gnt_valid=0, preempt=0, idle=1.
  - Internal: ptr=0, hold_cnt=0, state=IDLE.
- Search: pick the lowest index i with req[i]=1 and i>=ptr. If none, wrap and pick the lowest i<ptr with req[i]=1. This is the masked priority encoder.
- IDLE state:
  - If |req=0, stay in IDLE.
  - Otherwise, at the next edge: set the grant to the search winner, state=GRANT, hold_cnt=0, idle=0.
  - Latency: req seen at edge k gives gnt at edge k+1.
- GRANT state, owner o:
  - req[o]=1, and either hold_cnt<MAX_HOLD-1 or no other req bit set:
    - Keep the grant.
    - hold_cnt increments and saturates at MAX_HOLD-1.
  - req[o]=0 (release):
    - ptr=(o+1) mod 8.
    - Search the remaining requests with that new ptr. If a winner exists, grant it at the next edge (back-to-back, no idle bubble) and reset hold_cnt=0.
    - If no winner, go to IDLE with gnt=0.
  - req[o]=1, hold_cnt==MAX_HOLD-1, another req bit set, and MAX_HOLD!=0 (preempt):
    - Pulse preempt=1 for one cycle, aligned with the new grant.
    - ptr=(o+1) mod 8; grant the search winner, which is never o; hold_cnt=0.
- MAX_HOLD=0: hold_cnt is unused and a grant is held until release.
- MAX_HOLD=1: the grant rotates every cycle while at least 2 requesters are active.
- Invariants:
  - gnt is always one-hot or zero.
  - gnt_idx always matches gnt.
  - At most one owner changes per cycle.
  - Glitch-free: all outputs come directly from flops.
- Wrap-around: an owner at index 7 sets ptr to 0.
- Simultaneous release and a new request from the same index: the requester is not re-granted that cycle, because the search sees its req=0. It competes again from the next cycle.
- Reset mid-grant: gnt drops immediately (async). After release, the arbiter restarts from IDLE with ptr=0.
- req changes in non-owner bits never disturb an active grant.

Decomposition:
- Package arb_pkg:
  - Constants N_REQ=8, IDX_W=3.
  - State enum {ST_IDLE, ST_GRANT}.
  - Function onehot_to_idx.
- Sub-module pri_enc_masked, purely combinational:
  - Inputs: req[7:0], ptr[2:0].
  - Outputs: win_idx[2:0], win_valid.
  - Implemented as two 8:3 priority encoders (masked and unmasked). The masked result wins when non-empty.
- Top holds the FSM, ptr, hold_cnt, and output registers.

Test Plan:
- Reset, then req=8'h00 for 5 cycles -> idle=1, gnt=0, gnt_idx=0, gnt_valid=0 throughout.
- From reset, req=8'b1000_0001 held -> gnt=8'h01 one cycle later. Drop req[0] -> next cycle gnt=8'h80, gnt_idx=7, no idle cycle between. Drop req[7] -> IDLE next cycle; next grant search starts at ptr=0.
- MAX_HOLD=4, req=8'b0000_0110 held constant -> grant 1 for 4 cycles, then preempt pulse and gnt=8'h04 for 4 cycles, then back to 8'h02.
- MAX_HOLD=4, req=8'h10 only, held 20 cycles -> gnt=8'h10 throughout, preempt never asserted.
- Assert rst_n=0 mid-grant (gnt=8'h20) between clock edges -> gnt=0 and idle=1 immediately, without waiting for a clock edge. Release with req=8'hFF -> gnt=8'h01 at the first edge.
- Random req for 1000 cycles -> gnt stays one-hot or zero. A continuously requesting index is granted within 7*MAX_HOLD+7 cycles of asserting req.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared constants, FSM state type and helpers for the 8-way round-robin arbiter.
package arb_pkg;

    localparam int unsigned N_REQ  = 8;
    localparam int unsigned IDX_W  = 3;
    localparam int unsigned HOLD_W = 8;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_e;

    // Binary index of a one-hot vector; returns 0 for an all-zero vector.
    function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [N_REQ-1:0] oh);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < int'(N_REQ); i++) begin
            if (oh[i]) begin
                idx = idx | IDX_W'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/pri_enc_masked.sv
// Combinational round-robin search: lowest requester at or above ptr,
// otherwise lowest requester overall (wrap-around).
//   req       : request vector
//   ptr       : search start index
//   win_idx   : winning index (0 when no request)
//   win_valid : any request present
module pri_enc_masked
    import arb_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] win_idx,
    output logic             win_valid
);

    logic [N_REQ-1:0] mask;
    logic [N_REQ-1:0] req_masked;
    logic [IDX_W-1:0] idx_masked;
    logic [IDX_W-1:0] idx_raw;

    // Thermometer mask keeping indices >= ptr.
    always_comb begin
        mask = '0;
        for (int i = 0; i < int'(N_REQ); i++) begin
            mask[i] = (IDX_W'(i) >= ptr);
        end
    end

    assign req_masked = req & mask;

    // Two lowest-index-first encoders; scanning downward lets the lowest set bit win.
    always_comb begin
        idx_masked = '0;
        idx_raw    = '0;
        for (int i = int'(N_REQ) - 1; i >= 0; i--) begin
            if (req_masked[i]) begin
                idx_masked = IDX_W'(i);
            end
            if (req[i]) begin
                idx_raw = IDX_W'(i);
            end
        end
    end

    assign win_idx   = (|req_masked) ? idx_masked : idx_raw;
    assign win_valid = |req;

endmodule

// File: rtl/rr_arbiter_8.sv
// 8-way round-robin arbiter with registered one-hot grant and a hold limit
// that forces rotation while other requesters wait.
//   clk, rst_n : clock, asynchronous active-low reset
//   req        : level-sensitive request vector
//   gnt        : one-hot grant (registered)
//   gnt_idx    : binary index of the grant, 0 when none
//   gnt_valid  : a grant is active
//   preempt    : one-cycle pulse when the hold limit revokes a grant
//   idle       : arbiter is in IDLE
module rr_arbiter_8
    import arb_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_valid,
    output logic             preempt,
    output logic             idle
);

    localparam logic              HOLD_EN   = (MAX_HOLD != 0);
    localparam logic [HOLD_W-1:0] HOLD_LAST = (MAX_HOLD == 0) ? HOLD_W'(0) : HOLD_W'(MAX_HOLD - 1);

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  ptr_q, ptr_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [N_REQ-1:0]  gnt_q, gnt_d;
    logic [IDX_W-1:0]  gnt_idx_q, gnt_idx_d;
    logic              gnt_valid_q, gnt_valid_d;
    logic              preempt_q, preempt_d;
    logic              idle_q, idle_d;

    logic [N_REQ-1:0]  enc_req;
    logic [IDX_W-1:0]  enc_ptr;
    logic [IDX_W-1:0]  win_idx;
    logic              win_valid;
    logic [N_REQ-1:0]  win_oh;
    logic              owner_req;
    logic              others_req;

    // While granting, the owner is excluded and the search starts just past it,
    // so release and preemption both hand over to the next requester in rotation.
    assign enc_req    = (state_q == ST_GRANT) ? (req & ~gnt_q) : req;
    assign enc_ptr    = (state_q == ST_GRANT) ? (gnt_idx_q + IDX_W'(1)) : ptr_q;
    assign owner_req  = |(req & gnt_q);
    assign others_req = |(req & ~gnt_q);
    assign win_oh     = N_REQ'(1) << win_idx;

    pri_enc_masked u_pri_enc (
        .req       (enc_req),
        .ptr       (enc_ptr),
        .win_idx   (win_idx),
        .win_valid (win_valid)
    );

    // Next-state and output decode.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        hold_d    = hold_q;
        gnt_d     = gnt_q;
        preempt_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (win_valid) begin
                    state_d = ST_GRANT;
                    gnt_d   = win_oh;
                    hold_d  = '0;
                end
            end
            ST_GRANT: begin
                if (!owner_req) begin
                    ptr_d  = enc_ptr;
                    hold_d = '0;
                    if (win_valid) begin
                        gnt_d = win_oh;
                    end else begin
                        gnt_d   = '0;
                        state_d = ST_IDLE;
                    end
                end else if (HOLD_EN && (hold_q == HOLD_LAST) && others_req) begin
                    preempt_d = 1'b1;
                    ptr_d     = enc_ptr;
                    gnt_d     = win_oh;
                    hold_d    = '0;
                end else if (HOLD_EN && (hold_q != HOLD_LAST)) begin
                    hold_d = hold_q + HOLD_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
                hold_d  = '0;
            end
        endcase

        gnt_idx_d   = onehot_to_idx(gnt_d);
        gnt_valid_d = |gnt_d;
        idle_d      = (state_d == ST_IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            hold_q      <= '0;
            gnt_q       <= '0;
            gnt_idx_q   <= '0;
            gnt_valid_q <= 1'b0;
            preempt_q   <= 1'b0;
            idle_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            hold_q      <= hold_d;
            gnt_q       <= gnt_d;
            gnt_idx_q   <= gnt_idx_d;
            gnt_valid_q <= gnt_valid_d;
            preempt_q   <= preempt_d;
            idle_q      <= idle_d;
        end
    end

    assign gnt       = gnt_q;
    assign gnt_idx   = gnt_idx_q;
    assign gnt_valid = gnt_valid_q;
    assign preempt   = preempt_q;
    assign idle      = idle_q;

endmodule

// File: tb/tb_rr_arbiter_8.sv
// Self-checking bench for rr_arbiter_8 (MAX_HOLD=4). Directed scenarios push
// expected output vectors {gnt, gnt_idx, gnt_valid, preempt, idle} into a
// queue as stimulus is driven and pop them when the DUT output is sampled.
module tb_rr_arbiter_8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] req;
    logic [7:0] gnt;
    logic [2:0] gnt_idx;
    logic       gnt_valid;
    logic       preempt;
    logic       idle;

    logic [13:0] obs;
    logic [13:0] exp_q [$];
    int n_checks = 0;
    int n_fail   = 0;

    assign obs = {gnt, gnt_idx, gnt_valid, preempt, idle};

    always #5 clk = ~clk;

    rr_arbiter_8 #(.MAX_HOLD(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid),
        .preempt   (preempt),
        .idle      (idle)
    );

    function automatic logic [13:0] ev(input logic [7:0] g, input logic [2:0] i,
                                       input logic v, input logic p, input logic d);
        return {g, i, v, p, d};
    endfunction

    task automatic test_reset();
        logic [13:0] e;
        rst_n = 1'b0;
        req   = 8'h00;
        repeat (2) @(negedge clk);
        exp_q.push_back(ev(8'h00, 3'd0, 1'b0, 1'b0, 1'b1));
        e = exp_q.pop_front();
        n_checks++;
        if (obs !== e) begin
            n_fail++;
            $display("FAIL reset_state: got %h expected %h", obs, e);
        end
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            req = 8'h00;
            exp_q.push_back(ev(8'h00, 3'd0, 1'b0, 1'b0, 1'b1));
            @(posedge clk);
            @(negedge clk);
            e = exp_q.pop_front();
            n_checks++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL idle_no_req step %0d: got %h expected %h", k, obs, e);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0]  rq [7];
        logic [13:0] ex [7];
        logic [13:0] e;
        rq = '{8'h81, 8'h81, 8'h80, 8'h80, 8'h00, 8'h81, 8'h00};
        ex = '{ev(8'h01, 3'd0, 1'b1, 1'b0, 1'b0),
               ev(8'h01, 3'd0, 1'b1, 1'b0, 1'b0),
               ev(8'h80, 3'd7, 1'b1, 1'b0, 1'b0),
               ev(8'h80, 3'd7, 1'b1, 1'b0, 1'b0),
               ev(8'h00, 3'd0, 1'b0, 1'b0, 1'b1),
               ev(8'h01, 3'd0, 1'b1, 1'b0, 1'b0),
               ev(8'h00, 3'd0, 1'b0, 1'b0, 1'b1)};
        for (int k = 0; k < 7; k++) begin
            req = rq[k];
            exp_q.push_back(ex[k]);
            @(posedge clk);
            @(negedge clk);
            e = exp_q.pop_front();
            n_checks++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL back_to_back step %0d: got %h expected %h", k, obs, e);
            end
        end
    endtask

    // ptr is 1 on entry; requesters 1 and 2 alternate every 4 cycles.
    task automatic test_preempt();
        logic [13:0] ex [13];
        logic [13:0] e;
        ex = '{ev(8'h02, 3'd1, 1'b1, 1'b0, 1'b0),
               ev(8'h02, 3'd1, 1'b1, 1'b0, 1'b0),
               ev(8'h02, 3'd1, 1'b1, 1'b0, 1'b0),
               ev(8'h02, 3'd1, 1'b1, 1'b0, 1'b0),
               ev(8'h04, 3'd2, 1'b1, 1'b1, 1'b0),
               ev(8'h04, 3'd2, 1'b1, 1'b0, 1'b0),
               ev(8'h04, 3'd2, 1'b1, 1'b0, 1'b0),
               ev(8'h04, 3'd2, 1'b1, 1'b0, 1'b0),
               ev(8'h02, 3'd1, 1'b1, 1'b1, 1'b0),
               ev(8'h02, 3'd1, 1'b1, 1'b0, 1'b0),
               ev(8'h02, 3'd1, 1'b1, 1'b0, 1'b0),
               ev(8'h02, 3'd1, 1'b1, 1'b0, 1'b0),
               ev(8'h00, 3'd0, 1'b0, 1'b0, 1'b1)};
        for (int k = 0; k < 13; k++) begin
            req = (k < 12) ? 8'h06 : 8'h00;
            exp_q.push_back(ex[k]);
            @(posedge clk);
            @(negedge clk);
            e = exp_q.pop_front();
            n_checks++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL preempt step %0d: got %h expected %h", k, obs, e);
            end
        end
    endtask

    task automatic test_single_hold();
        logic [13:0] e;
        for (int k = 0; k < 21; k++) begin
            req = (k < 20) ? 8'h10 : 8'h00;
            exp_q.push_back((k < 20) ? ev(8'h10, 3'd4, 1'b1, 1'b0, 1'b0)
                                     : ev(8'h00, 3'd0, 1'b0, 1'b0, 1'b1));
            @(posedge clk);
            @(negedge clk);
            e = exp_q.pop_front();
            n_checks++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL single_hold step %0d: got %h expected %h", k, obs, e);
            end
        end
    endtask

    task automatic test_async_reset();
        logic [13:0] e;
        req = 8'h20;
        exp_q.push_back(ev(8'h20, 3'd5, 1'b1, 1'b0, 1'b0));
        @(posedge clk);
        @(negedge clk);
        e = exp_q.pop_front();
        n_checks++;
        if (obs !== e) begin
            n_fail++;
            $display("FAIL async_pre_grant: got %h expected %h", obs, e);
        end
        #2 rst_n = 1'b0;
        exp_q.push_back(ev(8'h00, 3'd0, 1'b0, 1'b0, 1'b1));
        #1;
        e = exp_q.pop_front();
        n_checks++;
        if (obs !== e) begin
            n_fail++;
            $display("FAIL async_reset_drop: got %h expected %h", obs, e);
        end
        @(negedge clk);
        req   = 8'hFF;
        rst_n = 1'b1;
        exp_q.push_back(ev(8'h01, 3'd0, 1'b1, 1'b0, 1'b0));
        @(posedge clk);
        @(negedge clk);
        e = exp_q.pop_front();
        n_checks++;
        if (obs !== e) begin
            n_fail++;
            $display("FAIL async_restart: got %h expected %h", obs, e);
        end
        req = 8'h00;
        exp_q.push_back(ev(8'h00, 3'd0, 1'b0, 1'b0, 1'b1));
        @(posedge clk);
        @(negedge clk);
        e = exp_q.pop_front();
        n_checks++;
        if (obs !== e) begin
            n_fail++;
            $display("FAIL async_back_idle: got %h expected %h", obs, e);
        end
    endtask

    // Slowly toggling random requests; grant legality and starvation bound.
    task automatic test_random();
        logic [7:0] r;
        logic [7:0] seen;
        logic [7:0] exp_g;
        int         wait_c [8];
        int         worst;
        r = 8'($urandom);
        for (int b = 0; b < 8; b++) wait_c[b] = 0;
        for (int c = 0; c < 1000; c++) begin
            for (int b = 0; b < 8; b++) begin
                if ($urandom_range(7) == 0) r[b] = ~r[b];
            end
            req  = r;
            seen = r;
            @(posedge clk);
            @(negedge clk);
            exp_g = gnt_valid ? (8'h01 << gnt_idx) : 8'h00;
            n_checks++;
            if (gnt !== exp_g || (!gnt_valid && gnt_idx !== 3'd0)) begin
                n_fail++;
                $display("FAIL rand_onehot cycle %0d: gnt %h idx %0d valid %b, required one-hot matching idx",
                         c, gnt, gnt_idx, gnt_valid);
            end
            n_checks++;
            if ((gnt & ~seen) !== 8'h00) begin
                n_fail++;
                $display("FAIL rand_grant_w/o_req cycle %0d: gnt %h req %h", c, gnt, seen);
            end
            worst = 0;
            for (int b = 0; b < 8; b++) begin
                if (seen[b] && !gnt[b]) wait_c[b]++;
                else wait_c[b] = 0;
                if (wait_c[b] > worst) worst = wait_c[b];
            end
            n_checks++;
            if (worst > 35) begin
                n_fail++;
                $display("FAIL rand_starvation cycle %0d: wait %0d, limit 35", c, worst);
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        req   = 8'h00;
        test_reset();
        test_back_to_back();
        test_preempt();
        test_single_hold();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
